// File: rtl/tone_mix_i2s.sv
// N-channel square-wave tone mixer with saturating volume and a left-justified serial DAC transmitter.
// Optional volume fade (applied_vol slews toward vol_level every 64 frames) under TONE_MIX_FADE_EN.
module tone_mix_chan #(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             sq
);
    logic [DIV_W-1:0] tc_q, tc_d;
    logic             sq_q, sq_d;

    // >= rather than == so a lowered divider takes effect on the next cycle
    always_comb begin
        tc_d = tc_q;
        sq_d = sq_q;
        if (!en || div == '0) begin
            tc_d = '0;
            sq_d = 1'b0;
        end else if (tc_q >= div - DIV_W'(1)) begin
            tc_d = '0;
            sq_d = ~sq_q;
        end else begin
            tc_d = tc_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q <= '0;
            sq_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
endmodule

module tone_mix_i2s #(
    parameter int CHANNELS  = 2,
    parameter int DIV_W     = 22,
    parameter int VOL_W     = 3,
    parameter int VOL_RESET = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      music_en,
    input  logic                      up_pulse,
    input  logic                      down_pulse,
    input  logic [CHANNELS*DIV_W-1:0] note_div,
    output logic [VOL_W-1:0]          vol_level,
    output logic                      audio_mclk,
    output logic                      audio_lrck,
    output logic                      audio_sck,
    output logic                      audio_sdin
);
    localparam int ACC_W = 16 + $clog2(CHANNELS);
    localparam logic [VOL_W-1:0] VMAX = '1;

    logic [8:0]       cnt_q, cnt_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [VOL_W-1:0] applied_vol;
    logic [15:0]      hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [CHANNELS-1:0] sq;
    logic signed [ACC_W-1:0] amp, contrib, sum_l, sum_r;
    logic latch;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        tone_mix_chan #(.DIV_W(DIV_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (music_en),
            .div   (note_div[k*DIV_W +: DIV_W]),
            .sq    (sq[k])
        );
    end

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] s);
        logic [ACC_W-16:0] hi;
        hi = s[ACC_W-1:15];
        if (hi == '0 || hi == '1) sat16 = s[15:0];
        else if (s[ACC_W-1])      sat16 = 16'h8000;
        else                      sat16 = 16'h7FFF;
    endfunction

    always_comb begin
        amp     = ACC_W'(applied_vol) << 10;
        contrib = '0;
        sum_l   = '0;
        sum_r   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            contrib = '0;
            if (music_en && note_div[k*DIV_W +: DIV_W] != '0)
                contrib = sq[k] ? amp : -amp;
            if (k % 2 == 0) sum_l = sum_l + contrib;
            else            sum_r = sum_r + contrib;
        end
        if (CHANNELS == 1) sum_r = sum_l;
    end

    assign latch = (cnt_q == 9'h1FF);

    always_comb begin
        cnt_d    = cnt_q + 9'd1;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (latch) begin
            hold_l_d = sat16(sum_l);
            hold_r_d = sat16(sum_r);
        end
        vol_d = vol_q;
        if (up_pulse && !down_pulse && vol_q != VMAX)
            vol_d = vol_q + VOL_W'(1);
        else if (down_pulse && !up_pulse && vol_q != '0)
            vol_d = vol_q - VOL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            vol_q    <= VOL_W'(VOL_RESET);
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            vol_q    <= vol_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
        end
    end

`ifdef TONE_MIX_FADE_EN
    logic [VOL_W-1:0] av_q, av_d;
    logic [5:0]       fcnt_q, fcnt_d;

    always_comb begin
        av_d   = av_q;
        fcnt_d = fcnt_q;
        if (latch) begin
            fcnt_d = fcnt_q + 6'd1;
            if (fcnt_q == '0) begin
                if (av_q < vol_q)      av_d = av_q + VOL_W'(1);
                else if (av_q > vol_q) av_d = av_q - VOL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            av_q   <= VOL_W'(VOL_RESET);
            fcnt_q <= '0;
        end else begin
            av_q   <= av_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign applied_vol = av_q;
`else
    assign applied_vol = vol_q;
`endif

    assign vol_level  = vol_q;
    assign audio_mclk = cnt_q[1];
    assign audio_sck  = cnt_q[3];
    assign audio_lrck = cnt_q[8];
    // bit index 15 - cnt[7:4]; only moves when cnt[3:0] wraps, i.e. while sck is low
    assign audio_sdin = cnt_q[8] ? hold_r_q[~cnt_q[7:4]] : hold_l_q[~cnt_q[7:4]];
endmodule

// File: tb/tb_tone_mix_i2s.sv
// Scoreboard bench for tone_mix_i2s: arithmetic tone model pushes expected frames, a monitor deserialises sdin.
module tb_tone_mix_i2s;
    localparam int CH = 10, DIV_W = 22, VOL_W = 3, VOL_RESET = 4;

    logic clk = 1'b0, rst_n = 1'b0, music_en = 1'b0, up_pulse = 1'b0, down_pulse = 1'b0;
    logic [CH*DIV_W-1:0] note_div = '0;
    logic [VOL_W-1:0] vol_level;
    logic audio_mclk, audio_lrck, audio_sck, audio_sdin;

    tone_mix_i2s #(.CHANNELS(CH), .DIV_W(DIV_W), .VOL_W(VOL_W), .VOL_RESET(VOL_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .music_en(music_en), .up_pulse(up_pulse),
        .down_pulse(down_pulse), .note_div(note_div), .vol_level(vol_level),
        .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_sck(audio_sck),
        .audio_sdin(audio_sdin)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int unsigned divs[CH];
    logic [31:0] expq[$];
    int unsigned mk = 0;     // posedges since reset release == expected cnt (mod 512)
    int unsigned ncyc = 0;   // consecutive enabled cycles: square phase = (ncyc / div) % 2
    int vm = VOL_RESET, av = VOL_RESET, lc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat(input int v);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic logic [31:0] model_frame(input int unsigned n, input int vol, input bit en);
        int l = 0, r = 0, c;
        for (int k = 0; k < CH; k++) begin
            if (en && divs[k] != 0) begin
                c = (((n / divs[k]) % 2) == 1) ? vol * 1024 : -(vol * 1024);
                if (k % 2 == 0) l += c; else r += c;
            end
        end
        return {sat(l), sat(r)};
    endfunction

    // reference model: one expected frame per latch point
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk = 0; ncyc = 0; vm = VOL_RESET; av = VOL_RESET; lc = 0;
            expq.delete();
            expq.push_back(32'h0);
        end else begin
            if (mk % 512 == 511) begin
`ifdef TONE_MIX_FADE_EN
                expq.push_back(model_frame(ncyc, av, music_en));
                if (lc % 64 == 0) av = (av < vm) ? av + 1 : (av > vm) ? av - 1 : av;
                lc++;
`else
                expq.push_back(model_frame(ncyc, vm, music_en));
`endif
            end
            if (up_pulse && !down_pulse && vm < 7) vm++;
            else if (down_pulse && !up_pulse && vm > 0) vm--;
            ncyc = music_en ? ncyc + 1 : 0;
            mk++;
        end
    end

    // monitor: deserialise each frame, check derived clocks, pop and compare at frame end
    logic [31:0] fbits = '0;
    bit clk_bad = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            automatic int unsigned c = mk % 512;
            automatic logic [31:0] e;
            if (audio_mclk !== c[1] || audio_sck !== c[3] || audio_lrck !== c[8]) clk_bad = 1;
            if (c % 16 == 8) fbits[31 - (c >> 4)] = audio_sdin;
            if (c == 511) begin
                chk("clocks", int'(clk_bad), 0);
                clk_bad = 0;
                chk("vol_level", int'(vol_level), vm);
                if (expq.size() == 0) chk("queue_empty", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("frame", int'(fbits), int'(e));
                end
            end
        end
    end

    task automatic set_divs;
        for (int k = 0; k < CH; k++) note_div[k*DIV_W +: DIV_W] = DIV_W'(divs[k]);
    endtask

    task automatic pulse(input bit u, input bit d);
        @(negedge clk); up_pulse = u; down_pulse = d;
        @(negedge clk); up_pulse = 0; down_pulse = 0;
    endtask

    task automatic set_vol(input int t);
        for (int i = 0; i < 16; i++) begin
            if (int'(vol_level) < t) pulse(1, 0);
            else if (int'(vol_level) > t) pulse(0, 1);
        end
    endtask

    task automatic frames(input int n, input bit rnd);
        repeat (n * 512) begin
            @(negedge clk);
            if (rnd) begin
                automatic int r = $urandom_range(0, 199);
                up_pulse = (r == 0) || (r == 2);
                down_pulse = (r == 1) || (r == 2);
            end
        end
        up_pulse = 0; down_pulse = 0;
    endtask

    task automatic wait_cnt(input int unsigned c);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (mk % 512 == c) return;
        end
        chk("wait_cnt_timeout", 1, 0);
    endtask

    initial begin
        int unsigned rise_l, sck1, sck2;
        bit p_l, p_s, sd_or;
        for (int k = 0; k < CH; k++) divs[k] = 0;
        repeat (3) @(negedge clk);
        chk("rst_pins", {audio_mclk, audio_lrck, audio_sck, audio_sdin}, 0);
        rst_n = 1'b1;
        chk("rst_vol", int'(vol_level), VOL_RESET);
        chk("rst_pins_rel", {audio_mclk, audio_lrck, audio_sck, audio_sdin}, 0);
        rise_l = 0; sck1 = 0; sck2 = 0; sd_or = 0; p_l = 0; p_s = 0;
        for (int i = 0; i < 511; i++) begin
            @(negedge clk);
            sd_or |= audio_sdin;
            if (audio_lrck && !p_l && rise_l == 0) rise_l = mk;
            if (audio_sck && !p_s) begin
                if (sck1 == 0) sck1 = mk; else if (sck2 == 0) sck2 = mk;
            end
            p_l = audio_lrck; p_s = audio_sck;
        end
        chk("lrck_first_rise", int'(rise_l), 256);
        chk("sck_period", int'(sck2 - sck1), 16);
        chk("sdin_first_frame", int'(sd_or), 0);

        repeat (5) pulse(1, 0);
        chk("vol_sat_hi", int'(vol_level), 7);
        repeat (10) pulse(0, 1);
        chk("vol_sat_lo", int'(vol_level), 0);
        repeat (3) pulse(1, 0);
        pulse(1, 1);
        chk("vol_both", int'(vol_level), 3);

        // single tone on ch0, left only
        set_vol(4);
        @(negedge clk); divs[0] = 1000; set_divs(); music_en = 1;
        frames(10, 0);

        // every channel in phase at full volume: left and right both saturate
        @(negedge clk); music_en = 0;
        for (int k = 0; k < CH; k++) divs[k] = 300;
        set_divs(); set_vol(7);
        @(negedge clk); music_en = 1;
        frames(6, 0);

        // enable drop mid-frame
        wait_cnt(100); music_en = 0;
        frames(3, 0);
        chk("tc0_cleared", int'(dut.g_ch[0].u_ch.tc_q), 0);

        // randomized segments
        for (int s = 0; s < 6; s++) begin
            @(negedge clk); music_en = 0;
            for (int k = 0; k < CH; k++)
                divs[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 800);
            set_divs(); set_vol($urandom_range(0, 7));
            @(negedge clk); music_en = 1;
            frames($urandom_range(3, 6), 1);
        end

        // reset mid-frame while playing
        wait_cnt(200); rst_n = 0;
        repeat (2) @(negedge clk);
        chk("midrst_pins", {audio_mclk, audio_lrck, audio_sck, audio_sdin}, 0);
        rst_n = 1;
        frames(4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tone_mix_i2s.md
# tone_mix_i2s

Parametrised N-channel square-wave tone mixer with saturating volume control and an on-chip serial audio transmitter. It replaces the fixed two-channel music path: it takes per-channel note dividers and single-cycle volume pulses from the control logic, mixes the channels into signed 16-bit left and right samples, and drives the speaker DAC pins directly from one system clock.

## Interface
Parameters:
- CHANNELS, 2: number of tone channels, 1..16. Even-indexed channels go to the left output, odd-indexed channels go to the right.
- DIV_W, 22: width of each note half-period divider.
- VOL_W, 3: volume register width. The maximum level is 2^VOL_W-1.
- VOL_RESET, 4: volume level loaded at reset.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- music_en  in  1  enables tone generation. When 0, the outputs carry silent frames.
- up_pulse  in  1  single-cycle volume increment request.
- down_pulse  in  1  single-cycle volume decrement request.
- note_div  in  CHANNELS*DIV_W  channel k is in bits [k*DIV_W +: DIV_W]. The value is the half-period in clk cycles; 0 means the channel is silent.
- vol_level  out  VOL_W  current volume register.
- audio_mclk  out  1  master clock, clk/4.
- audio_lrck  out  1  word select: 0 = left, 1 = right. Period 512 clk.
- audio_sck  out  1  bit clock, clk/16.
- audio_sdin  out  1  serial data, MSB first.

## Operation
- cnt is a free-running 9-bit counter, cleared by reset.
  - audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[8].
  - The counter and derived clocks run regardless of music_en.
- Tone channel k:
  - Has a DIV_W counter tc_k and a square bit sq_k.
  - If music_en=0 or div_k=0: tc_k is held at 0 and sq_k is held at 0.
  - Otherwise, when tc_k >= div_k-1, tc_k wraps to 0 and sq_k toggles; else tc_k increments.
  - The >= compare makes a lowered divider take effect within one cycle.
- Channel contribution: A = applied_vol * 16'h0400.
  - +A when sq_k=1, -A when sq_k=0.
  - 0 if div_k=0 or music_en=0.
- Mixing:
  - Contributions are summed per side in a signed accumulator of width 16+clog2(CHANNELS).
  - Each side's sum saturates to the range [0x8000, 0x7FFF].
  - If CHANNELS=1, right mirrors left.
- Sample latch: at cnt==9'h1FF, the saturated left and right values load into hold registers.
- Serialisation:
  - audio_sdin = bit (15 - cnt[7:4]) of hold_left when cnt[8]=0, and of hold_right when cnt[8]=1.
  - Data changes only while audio_sck is low.
  - Format is left-justified with no one-bit delay.
- Volume control:
  - up_pulse alone: +1, saturating at the maximum level.
  - down_pulse alone: -1, saturating at 0.
  - Both asserted in the same cycle: no change.
  - applied_vol = vol_level, except where the fade option below is compiled in.

## Timing
- Reset values:
  - cnt=0, all tc_k=0, all sq_k=0, hold registers 0.
  - vol_level=VOL_RESET.
  - audio_mclk, audio_lrck, audio_sck and audio_sdin all 0.
- vol_level updates on the clk edge after a pulse (1-cycle latency).
- Mixer paths are combinational from registers, sampled only at the latch point. A note or volume change is audible in the frame that starts at the next cnt wrap: at most 512 cycles plus 1.
- Deasserting music_en mid-frame:
  - The current frame finishes with its held samples.
  - Every following frame is 0x0000 on both sides.
- Reset asserted mid-frame clears every register immediately. The first frame after release is all zeros.

## Configuration
- TONE_MIX_FADE_EN defined:
  - applied_vol is a separate register, reset to VOL_RESET.
  - At each sample latch whose frame index is a multiple of 64 (a 6-bit frame counter wraps to 0), applied_vol steps by 1 toward vol_level.
- TONE_MIX_FADE_EN undefined: applied_vol is identical to vol_level, and no frame counter exists.

## Test plan
- Reset check: release rst_n. Required: all pins 0, vol_level=4, first rising audio_lrck at cycle 256, audio_sck period 16 cycles, audio_sdin=0 for the first 512 cycles.
- Volume saturation:
  - From level 4, 5 up_pulses give vol_level=7.
  - Then 10 down_pulses give 0.
  - A simultaneous up_pulse and down_pulse at level 3 leaves 3.
- Single tone: CHANNELS=2, ch0 div=1000, ch1 div=0, vol=4, music_en=1. Required: left words are 16'h1000 or 16'hF000 and alternate at the square rate; right words are 16'h0000.
- Saturation: CHANNELS=10, vol=7, all div=300 and in phase. Required: left words are 16'h7FFF / 16'h8000, never wrapped.
- Enable drop: music_en falls at cnt=100. Required: the current frame is unchanged; the following frames are all-zero bits; all tc_k=0.
- Fade (TONE_MIX_FADE_EN defined): vol changes 4→7. Required: applied_vol reaches 7 after 3 fade steps (≤ 192 frames), and the sample amplitude rises 0x1000→0x1400→0x1800→0x1C00.
